// File: rtl/can_bit_timing.sv
// CAN bit-timing stage: splits clk into time quanta, samples RX once per bit and
// keeps the bit grid aligned to bus edges via hard sync and bounded resync.
module can_bit_timing #(
    parameter int BRP   = 1,
    parameter int TSEG1 = 3,
    parameter int TSEG2 = 2,
    parameter int SJW   = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_raw,
    input  logic bus_idle,
    output logic rx_bit,
    output logic sample_point,
    output logic tx_point,
    output logic hard_sync
);

    localparam int PW = (BRP > 1) ? $clog2(BRP) : 1;
    localparam int IW = $clog2(TSEG1 + SJW + TSEG2 + 2);

    localparam logic [PW-1:0] PMAX = PW'(BRP - 1);
    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [IW-1:0] IONE = IW'(1);
    localparam logic [IW-1:0] T1M1 = IW'(TSEG1 - 1);
    localparam logic [IW-1:0] T2   = IW'(TSEG2);
    localparam logic [IW-1:0] SJWV = IW'(SJW);
    localparam logic [IW-1:0] E2N  = IW'(TSEG2 - 1);
    localparam logic [IW-1:0] E2S  = IW'(TSEG2 - SJW - 1);

    typedef enum logic [1:0] {
        ST_SYNC,
        ST_SEG1,
        ST_SEG2
    } state_t;

    logic          sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic          last_q, last_d, rx_bit_q, rx_bit_d;
    logic          sp_q, sp_d, tx_q, tx_d, hs_q, hs_d;
    logic          rdone_q, rdone_d, shrt_q, shrt_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [IW-1:0] idx_q, idx_d, ext_q, ext_d;
    state_t        state_q, state_d;

    logic          rx_s, fall, tq_tick, hs_ev, rs_ev, jump, shrt_v;
    logic [IW-1:0] ext_v;

    assign rx_s    = sync2_q;
    assign fall    = !rx_s && prev_q;
    assign tq_tick = (pre_q == PMAX);
    assign hs_ev   = fall && bus_idle;
    assign rs_ev   = fall && !bus_idle && last_q && !rdone_q;

    always_comb begin
        sync1_d  = rx_raw;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        last_d   = last_q;
        rx_bit_d = rx_bit_q;
        sp_d     = 1'b0;
        tx_d     = 1'b0;
        hs_d     = 1'b0;
        rdone_d  = rdone_q;
        shrt_d   = shrt_q;
        ext_d    = ext_q;
        idx_d    = idx_q;
        state_d  = state_q;
        pre_d    = tq_tick ? '0 : pre_q + PONE;
        ext_v    = ext_q;
        shrt_v   = shrt_q;
        jump     = 1'b0;

        if (hs_ev) begin
            state_d = ST_SYNC;
            idx_d   = '0;
            pre_d   = '0;
            ext_d   = '0;
            shrt_d  = 1'b0;
            hs_d    = 1'b1;
            tx_d    = 1'b1;
            rdone_d = 1'b1;
        end else begin
            // Phase error is judged on the tq index before this cycle's tick.
            if (rs_ev) begin
                rdone_d = 1'b1;
                unique case (state_q)
                    ST_SEG1: ext_v = (idx_q + IONE > SJWV) ? SJWV : idx_q + IONE;
                    ST_SEG2: begin
                        if (T2 - idx_q <= SJWV) jump = 1'b1;
                        else shrt_v = 1'b1;
                    end
                    default: ;
                endcase
            end
            ext_d  = ext_v;
            shrt_d = shrt_v;

            if (jump) begin
                state_d = ST_SYNC;
                idx_d   = '0;
                pre_d   = '0;
                ext_d   = '0;
                shrt_d  = 1'b0;
                tx_d    = 1'b1;
            end else if (tq_tick) begin
                unique case (state_q)
                    ST_SYNC: begin
                        state_d = ST_SEG1;
                        idx_d   = '0;
                    end
                    ST_SEG1: begin
                        if (idx_q >= T1M1 + ext_v) begin
                            state_d  = ST_SEG2;
                            idx_d    = '0;
                            sp_d     = 1'b1;
                            rx_bit_d = rx_s;
                            last_d   = rx_s;
                            rdone_d  = 1'b0;
                        end else begin
                            idx_d = idx_q + IONE;
                        end
                    end
                    ST_SEG2: begin
                        if (idx_q >= (shrt_v ? E2S : E2N)) begin
                            state_d = ST_SYNC;
                            idx_d   = '0;
                            ext_d   = '0;
                            shrt_d  = 1'b0;
                            tx_d    = 1'b1;
                        end else begin
                            idx_d = idx_q + IONE;
                        end
                    end
                    default: state_d = ST_SYNC;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            prev_q   <= 1'b1;
            last_q   <= 1'b1;
            rx_bit_q <= 1'b1;
            sp_q     <= 1'b0;
            tx_q     <= 1'b0;
            hs_q     <= 1'b0;
            rdone_q  <= 1'b0;
            shrt_q   <= 1'b0;
            pre_q    <= '0;
            idx_q    <= '0;
            ext_q    <= '0;
            state_q  <= ST_SYNC;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            prev_q   <= prev_d;
            last_q   <= last_d;
            rx_bit_q <= rx_bit_d;
            sp_q     <= sp_d;
            tx_q     <= tx_d;
            hs_q     <= hs_d;
            rdone_q  <= rdone_d;
            shrt_q   <= shrt_d;
            pre_q    <= pre_d;
            idx_q    <= idx_d;
            ext_q    <= ext_d;
            state_q  <= state_d;
        end
    end

    assign rx_bit       = rx_bit_q;
    assign sample_point = sp_q;
    assign tx_point     = tx_q;
    assign hard_sync    = hs_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// Directed bench for can_bit_timing: default instance plus an SJW=2 instance
// sharing the same RX stimulus.
module tb_can_bit_timing;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic rx_raw = 1'b1;
    logic bus_idle = 1'b1;
    logic rb1, sp1, tx1, hs1;
    logic rb2, sp2, tx2, hs2;
    int   n_pass = 0;
    int   n_tot  = 0;

    always #5 clk = ~clk;

    can_bit_timing u_dut1 (
        .clk(clk), .rst(rst), .rx_raw(rx_raw), .bus_idle(bus_idle),
        .rx_bit(rb1), .sample_point(sp1), .tx_point(tx1), .hard_sync(hs1)
    );

    can_bit_timing #(.SJW(2)) u_dut2 (
        .clk(clk), .rst(rst), .rx_raw(rx_raw), .bus_idle(bus_idle),
        .rx_bit(rb2), .sample_point(sp2), .tx_point(tx2), .hard_sync(hs2)
    );

    typedef struct {
        logic rx;
        logic idle;
        logic sp;
        logic tx;
        logic hs;
        logic rb;
    } vec_t;

    vec_t tbl [12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tot++;
        if (act !== exp)
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_sp(input bit d2, output int n);
        n = -1;
        for (int i = 1; i <= 20 && n < 0; i++) begin
            tick();
            if (d2 ? sp2 : sp1) n = i;
        end
    endtask

    initial begin
        int n, a1, b1, a2;
        logic r1;

        // rx, idle, sp, tx, hs, rx_bit after each clock following reset release
        tbl = '{
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1},
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 1, 0, 0, 1},
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 0, 1, 0, 1},
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 0, 0, 0, 1},
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 1, 0, 0, 1},
            '{1, 1, 0, 0, 0, 1}, '{1, 1, 0, 1, 0, 1}
        };

        rst = 1'b0;
        tick();
        tick();
        chk("rst_rx_bit", rb1, 1);
        chk("rst_sp", sp1, 0);
        chk("rst_tx", tx1, 0);
        chk("rst_hs", hs1, 0);
        chk("rst_rx_bit2", rb2, 1);
        rst = 1'b1;

        for (int k = 0; k < 12; k++) begin
            rx_raw   = tbl[k].rx;
            bus_idle = tbl[k].idle;
            tick();
            chk($sformatf("idle_sp[%0d]", k), sp1, tbl[k].sp);
            chk($sformatf("idle_tx[%0d]", k), tx1, tbl[k].tx);
            chk($sformatf("idle_hs[%0d]", k), hs1, tbl[k].hs);
            chk($sformatf("idle_rb[%0d]", k), rb1, tbl[k].rb);
        end

        // Hard sync: falling edge while idle
        bus_idle = 1'b1;
        rx_raw   = 1'b0;
        tick();
        tick();
        tick();
        chk("hs_pulse", hs1, 1);
        tick();
        chk("hs_one_clk", hs1, 0);
        chk("hs_no_sp4", sp1, 0);
        tick();
        chk("hs_no_sp5", sp1, 0);
        tick();
        chk("hs_no_sp6", sp1, 0);
        tick();
        chk("hs_sp7", sp1, 1);
        chk("hs_rx_bit", rb1, 0);
        wait_sp(0, n);
        chk("hs_next_bit", n, 6);

        // Resync in SEG1 index 1: SJW=1 gives 7 clk, SJW=2 gives 8 clk
        rx_raw   = 1'b1;
        bus_idle = 1'b0;
        do_reset();
        wait_sp(0, n);
        chk("first_sp_after_rst", n, 4);
        tick();
        tick();
        rx_raw = 1'b0;
        a1 = -1;
        b1 = -1;
        a2 = -1;
        r1 = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (sp1 && a1 >= 0 && b1 < 0) b1 = i;
            if (sp1 && a1 < 0) begin
                a1 = i;
                r1 = rb1;
            end
            if (sp2 && a2 < 0) a2 = i;
        end
        chk("seg1_bit_sjw1", a1 + 2, 7);
        chk("seg1_next_sjw1", b1 - a1, 6);
        chk("seg1_bit_sjw2", a2 + 2, 8);
        chk("seg1_rx_bit", r1, 0);

        // Glitch 0-1-0 in SEG1 on SJW=2 instance: only the first edge counts
        rx_raw = 1'b1;
        do_reset();
        wait_sp(1, n);
        tick();
        rx_raw = 1'b0;
        tick();
        rx_raw = 1'b1;
        tick();
        rx_raw = 1'b0;
        wait_sp(1, n);
        chk("glitch_bit", n + 3, 7);
        chk("glitch_rx_bit", rb2, 0);
        // Edge after a dominant sample is ignored
        rx_raw = 1'b1;
        tick();
        tick();
        rx_raw = 1'b0;
        wait_sp(1, n);
        chk("dom_edge_ignored", n + 2, 6);
        chk("dom_rx_bit", rb2, 0);

        // Edge in SEG2 index 0: both instances restart SYNC, 5 clk bit
        rx_raw = 1'b1;
        do_reset();
        wait_sp(0, n);
        tick();
        tick();
        tick();
        tick();
        rx_raw = 1'b0;
        wait_sp(0, n);
        chk("seg2_pre_sp", n + 4, 6);
        chk("seg2_pre_rx_bit", rb1, 1);
        a1 = -1;
        a2 = -1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (sp1 && a1 < 0) a1 = i;
            if (sp2 && a2 < 0) a2 = i;
        end
        chk("seg2_bit_sjw1", a1, 5);
        chk("seg2_bit_sjw2", a2, 5);

        // One-cycle reset in mid-SEG1
        rx_raw = 1'b1;
        do_reset();
        wait_sp(0, n);
        tick();
        tick();
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("mid_rst_sp", sp1, 0);
        chk("mid_rst_tx", tx1, 0);
        chk("mid_rst_hs", hs1, 0);
        chk("mid_rst_rx_bit", rb1, 1);
        rst = 1'b1;
        wait_sp(0, n);
        chk("mid_rst_first_sp", n, 4);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
